// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-way round-robin arbiter with registered one-hot and
// binary grant outputs.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined     : an owner that has held the grant for HOLD_MAX consecutive
//                 cycles is revoked as soon as another requester is waiting,
//                 and expire pulses for one cycle alongside the new grant.
//   Not defined : the owner keeps the grant until it releases, expire is
//                 tied low and HOLD_MAX has no effect.

module rr_arbiter_8 #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       expire
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   arb_state_t state;

   // First index examined by the next search; always one past the last winner.
   logic [2:0] ptr;

   // Candidates for the next search. Masking out the current owner costs
   // nothing in IDLE (gnt is zero) or on a release (its req bit is already
   // low), and gives the owner exclusion a hold-limit revocation needs.
   logic [7:0] cand;
   logic       pick_found;
   logic [2:0] pick_idx;

   // Decisions for the coming edge.
   logic take_new;
   logic go_idle;

   // Circular priority search: the lowest distance from start wins. Walking
   // the distances from far to near lets the nearest hit overwrite the rest.
   function automatic logic [3:0] rr_pick(input logic [7:0] vec,
                                          input logic [2:0] start);
      logic [3:0] result;
      logic [2:0] idx;
      result = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = start + 3'(k);
         if (vec[idx]) begin
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

   // A hold limit outside 1..255 cannot be represented by the 8-bit counter.
   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("rr_arbiter_8: HOLD_MAX must lie in 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   // Consecutive cycles the current owner has held the grant, minus one.
   logic [7:0] hcnt;
   logic       revoke;
   logic       expire_r;

   assign expire = expire_r;
`else
   assign expire = 1'b0;
`endif

   // Search the non-owner requesters starting from the round-robin pointer.
   always_comb begin
      logic [3:0] pick;
      cand       = req & ~gnt;
      pick       = rr_pick(cand, ptr);
      pick_found = pick[3];
      pick_idx   = pick[2:0];
   end

   // Decide whether the coming edge hands out a new grant or drops to idle.
   always_comb begin
      take_new = 1'b0;
      go_idle  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      revoke   = 1'b0;
`endif
      case (state)
         IDLE: begin
            take_new = pick_found;
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               take_new = pick_found;
               go_idle  = !pick_found;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hcnt == HOLD_LAST && pick_found) begin
               take_new = 1'b1;
               revoke   = 1'b1;
            end
`endif
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase
   end

   // Arbiter state machine; every output is a flop updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         gnt       <= 8'h00;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hcnt      <= 8'd0;
         expire_r  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         expire_r <= revoke;
`endif
         if (take_new) begin
            state     <= GRANT;
            gnt       <= 8'b1 << pick_idx;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            ptr       <= pick_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
            hcnt      <= 8'd0;
`endif
         end else if (go_idle) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hcnt      <= 8'd0;
`endif
         end
`ifdef ARB_TIMEOUT_EN
         else if (state == GRANT && hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 8'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8 -- scoreboard bench for rr_arbiter_8. A stimulus task drives
// req/rst, steps a behavioural arbiter model and queues the outputs expected
// after the next edge; a monitor pops and compares them on falling edges.
// Honours ARB_TIMEOUT_EN like the design, with HOLD_MAX set to 4.

module tb_rr_arbiter_8;

   localparam int HOLD_LIMIT = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       expire;

   typedef struct {
      int         cyc;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       expire;
   } exp_t;

   exp_t sbq[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // Model state: owner -1 means nobody holds the grant.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;

   rr_arbiter_8 #(.HOLD_MAX(HOLD_LIMIT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid),
      .expire   (expire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number of the most recent rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // First requester found walking start, start+1, ... around the ring.
   function automatic int firstFrom(input logic [7:0] v, input int start,
                                    input int excl);
      int i;
      for (int k = 0; k < 8; k++) begin
         i = (start + k) % 8;
         if (i != excl && v[i]) return i;
      end
      return -1;
   endfunction

   // Drive one cycle of inputs and queue what the arbiter must show after
   // the edge that samples them.
   task automatic applyStimulus(input logic [7:0] r, input logic rs);
      exp_t e;
      int   winner;
      logic m_expire;
      @(posedge clk);
      #1;
      req      = r;
      rst      = rs;
      m_expire = 1'b0;
      if (rs) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_owner < 0 || !r[m_owner]) begin
         winner = firstFrom(r, m_ptr, -1);
         if (winner >= 0) begin
            m_owner = winner;
            m_ptr   = (winner + 1) % 8;
            m_hold  = 1;
         end else begin
            m_owner = -1;
         end
      end else if (TIMEOUT_ON && m_hold >= HOLD_LIMIT &&
                   firstFrom(r, m_ptr, m_owner) >= 0) begin
         winner   = firstFrom(r, m_ptr, m_owner);
         m_owner  = winner;
         m_ptr    = (winner + 1) % 8;
         m_hold   = 1;
         m_expire = 1'b1;
      end else begin
         m_hold++;
      end
      e.cyc    = cyc + 1;
      e.gnt    = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      e.idx    = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      e.valid  = (m_owner >= 0);
      e.expire = m_expire;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.valid ||
          expire !== e.expire) begin
         errors++;
         $display("[TB] FAIL grant cycle %0d: got gnt=%b idx=%0d valid=%b expire=%b, expected gnt=%b idx=%0d valid=%b expire=%b",
                  cyc, gnt, gnt_idx, gnt_valid, expire,
                  e.gnt, e.idx, e.valid, e.expire);
      end
   endtask

   // Monitor: compare on the falling edge of the cycle each entry targets.
   initial begin
      forever begin
         @(negedge clk);
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            checkOutput(sbq.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] r;
      rst = 1'b1;
      req = 8'h00;

      // Reset with every requester asking, then a single request.
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      repeat (3) applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h00, 1'b0);

      // Single-requester sweep with an idle cycle between owners.
      for (int i = 0; i < 8; i++) begin
         repeat (3) applyStimulus(8'(1 << i), 1'b0);
         applyStimulus(8'h00, 1'b0);
      end

      // Rotation with wrap: each owner drops its bit briefly.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'hFF, 1'b0);
         applyStimulus(8'hFF, 1'b0);
         applyStimulus(8'hFF & ~8'(1 << ((m_owner < 0) ? 0 : m_owner)), 1'b0);
      end
      applyStimulus(8'h00, 1'b0);

      // Pointer fairness: after 5 releases the search wraps to 0, then 1, 5.
      applyStimulus(8'h20, 1'b0);
      applyStimulus(8'h20, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h23, 1'b0);
      applyStimulus(8'h23, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h23, 1'b0);
      applyStimulus(8'h21, 1'b0);
      applyStimulus(8'h21, 1'b0);
      applyStimulus(8'h00, 1'b0);

      // Reset mid-grant, then a full request vector searches from 0.
      repeat (3) applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h10, 1'b1);
      repeat (2) applyStimulus(8'hFF, 1'b0);

      // Hold limit: 2 hogs the grant, 6 joins later.
      applyStimulus(8'h00, 1'b1);
      repeat (10) applyStimulus(8'h04, 1'b0);
      repeat (12) applyStimulus(8'h44, 1'b0);
      applyStimulus(8'h00, 1'b0);

      // Randomised traffic with mostly stable request vectors.
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) r = r ^ 8'($urandom_range(255));
         if ($urandom_range(7) == 0) r = r & ~gnt_for_owner();
         applyStimulus(r, ($urandom_range(63) == 0));
      end

      // Drain: every queued expectation must be consumed.
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Model owner as a one-hot mask, used to make the random owner release.
   function automatic logic [7:0] gnt_for_owner();
      return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
   endfunction

endmodule
